// File: rtl/dir_reg_bank.sv
// Direction register bank.
// The bus write strobe comes from another clock domain, so it is synchronized
// and edge-detected. Each write is taken from the A/D/choose_dir_reg values
// sampled on the clock edge that sees the synchronized rising edge.
// All outputs come straight from flops.
module dir_reg_bank #(
    parameter int                N_REGS    = 4,
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 4,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_W-1:0]          A,
    input  logic [DATA_W-1:0]          D,
    input  logic                       strob_in,
    input  logic                       choose_dir_reg,
    output logic [N_REGS-1:0]          strob_out_to_reg,
    output logic [N_REGS*DATA_W-1:0]   dir_q,
    output logic                       wr_ack,
    output logic                       addr_err
);

    // One extra address bit, so that N_REGS = 2**ADDR_W still fits in the compare constant.
    localparam logic [ADDR_W:0] N_REGS_A = (ADDR_W + 1)'(N_REGS);

    logic                     s1_q, s2_q, s3_q;
    logic                     rise;
    logic                     in_range;
    logic                     accept;
    logic                     reject;
    logic [N_REGS-1:0]        sel_d;
    logic [N_REGS-1:0]        strobe_q;
    logic                     ack_q;
    logic                     err_q;
    logic [N_REGS*DATA_W-1:0] regs_q;

    // Two-flop synchronizer for strob_in, plus a history flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= strob_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Qualify the edge and decode the target register.
    always_comb begin
        rise     = s2_q & ~s3_q;
        in_range = ({1'b0, A} < N_REGS_A);
        accept   = rise & choose_dir_reg & in_range;
        reject   = rise & choose_dir_reg & ~in_range;
        sel_d    = '0;
        for (int i = 0; i < N_REGS; i++) begin
            sel_d[i] = accept & (A == ADDR_W'(i));
        end
    end

    // Register the strobe, ack and error pulses together with the register update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_q <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            regs_q   <= {N_REGS{RESET_VAL}};
        end else begin
            strobe_q <= sel_d;
            ack_q    <= accept;
            err_q    <= reject;
            for (int i = 0; i < N_REGS; i++) begin
                if (sel_d[i]) begin
                    regs_q[i*DATA_W +: DATA_W] <= D;
                end
            end
        end
    end

    assign strob_out_to_reg = strobe_q;
    assign wr_ack           = ack_q;
    assign addr_err         = err_q;
    assign dir_q            = regs_q;

endmodule

// File: tb/tb_dir_reg_bank.sv
// Bench for dir_reg_bank: table-driven writes checked through an event scoreboard,
// plus hand-written sequences for reset interaction and out-of-range addresses.
module tb_dir_reg_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    // Instance with 4 registers.
    logic [3:0]  a4 = '0;
    logic [7:0]  d4 = '0;
    logic        strob4 = 1'b0;
    logic        ch4 = 1'b0;
    logic [3:0]  strobe4;
    logic [31:0] dir4;
    logic        ack4, err4;

    // Instance with 5 registers and 3 address bits.
    logic [2:0]  a5 = '0;
    logic [7:0]  d5 = '0;
    logic        strob5 = 1'b0;
    logic        ch5 = 1'b0;
    logic [4:0]  strobe5;
    logic [39:0] dir5;
    logic        ack5, err5;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_cnt = 0;
    int acc_pushed = 0;

    typedef struct {
        logic [3:0]  strobe;
        logic        ack;
        logic        err;
        logic [31:0] dirq;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [3:0]  a;
        logic [7:0]  d;
        logic        ch;
        int          hold;
        int          gap;
        logic [3:0]  strobe;
        logic [31:0] dirq;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[9];

    dir_reg_bank #(.N_REGS(4), .DATA_W(8), .ADDR_W(4)) u4 (
        .clk(clk), .rst(rst), .A(a4), .D(d4), .strob_in(strob4), .choose_dir_reg(ch4),
        .strob_out_to_reg(strobe4), .dir_q(dir4), .wr_ack(ack4), .addr_err(err4)
    );

    dir_reg_bank #(.N_REGS(5), .DATA_W(8), .ADDR_W(3)) u5 (
        .clk(clk), .rst(rst), .A(a5), .D(d5), .strob_in(strob5), .choose_dir_reg(ch5),
        .strob_out_to_reg(strobe5), .dir_q(dir5), .wr_ack(ack5), .addr_err(err5)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor for the 4-register instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("onehot0", 64'($onehot0(strobe4)), 64'd1);
            chk("ack_err_excl", 64'(ack4 & err4), 64'd0);
            if (strobe4 != 4'd0 || ack4 || err4) begin
                if (ack4) ack_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_event", 64'({strobe4, ack4, err4}), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("ev_cycle", 64'(cyc), 64'(e.cyc));
                    chk("ev_strobe", 64'(strobe4), 64'(e.strobe));
                    chk("ev_ack", 64'(ack4), 64'(e.ack));
                    chk("ev_err", 64'(err4), 64'(e.err));
                    chk("ev_dirq", 64'(dir4), 64'(e.dirq));
                end
            end
        end
    end

    // Drive one write from the table; the expected output event lands 3 edges later.
    task automatic apply(input vec_t v);
        exp_t e;
        a4 = v.a;
        d4 = v.d;
        ch4 = v.ch;
        strob4 = 1'b1;
        if (v.ch) begin
            e.strobe = v.strobe;
            e.ack = 1'b1;
            e.err = 1'b0;
            e.dirq = v.dirq;
            e.cyc = cyc + 3;
            sb.push_back(e);
            acc_pushed++;
        end
        repeat (v.hold) @(negedge clk);
        strob4 = 1'b0;
        repeat (v.gap) @(negedge clk);
        chk("dirq_after_vec", 64'(dir4), 64'(v.dirq));
    endtask

    initial begin
        exp_t e;
        vecs[0] = '{a: 4'd2, d: 8'hA5, ch: 1'b1, hold: 4,  gap: 4, strobe: 4'b0100, dirq: 32'h00A5_0000};
        vecs[1] = '{a: 4'd0, d: 8'h11, ch: 1'b1, hold: 4,  gap: 4, strobe: 4'b0001, dirq: 32'h00A5_0011};
        vecs[2] = '{a: 4'd1, d: 8'h22, ch: 1'b1, hold: 4,  gap: 4, strobe: 4'b0010, dirq: 32'h00A5_2211};
        vecs[3] = '{a: 4'd2, d: 8'h33, ch: 1'b1, hold: 4,  gap: 4, strobe: 4'b0100, dirq: 32'h0033_2211};
        vecs[4] = '{a: 4'd3, d: 8'h44, ch: 1'b1, hold: 4,  gap: 4, strobe: 4'b1000, dirq: 32'h4433_2211};
        vecs[5] = '{a: 4'd1, d: 8'hFF, ch: 1'b0, hold: 4,  gap: 4, strobe: 4'b0000, dirq: 32'h4433_2211};
        vecs[6] = '{a: 4'd3, d: 8'h5A, ch: 1'b1, hold: 20, gap: 4, strobe: 4'b1000, dirq: 32'h5A33_2211};
        vecs[7] = '{a: 4'd0, d: 8'hC1, ch: 1'b1, hold: 2,  gap: 2, strobe: 4'b0001, dirq: 32'h5A33_22C1};
        vecs[8] = '{a: 4'd1, d: 8'hC2, ch: 1'b1, hold: 2,  gap: 6, strobe: 4'b0010, dirq: 32'h5A33_C2C1};

        // Asynchronous reset, checked before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("rst_dirq", 64'(dir4), 64'd0);
        chk("rst_strobe", 64'(strobe4), 64'd0);
        chk("rst_ack", 64'(ack4), 64'd0);
        chk("rst_err", 64'(err4), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Out-of-range address on the 5-register bank, then the top in-range register.
        a5 = 3'd6; d5 = 8'h77; ch5 = 1'b1; strob5 = 1'b1;
        repeat (3) @(negedge clk);
        chk("r5_err_pulse", 64'(err5), 64'd1);
        chk("r5_err_strobe", 64'(strobe5), 64'd0);
        chk("r5_err_ack", 64'(ack5), 64'd0);
        chk("r5_err_dirq", 64'(dir5), 64'd0);
        @(negedge clk);
        chk("r5_err_one_cycle", 64'(err5), 64'd0);
        strob5 = 1'b0;
        repeat (4) @(negedge clk);
        a5 = 3'd4; d5 = 8'hC3; strob5 = 1'b1;
        repeat (3) @(negedge clk);
        chk("r5_hi_strobe", 64'(strobe5), 64'b10000);
        chk("r5_hi_ack", 64'(ack5), 64'd1);
        chk("r5_hi_err", 64'(err5), 64'd0);
        chk("r5_hi_dirq", 64'(dir5), 64'h00C3_0000_0000);
        @(negedge clk);
        chk("r5_hi_strobe_clr", 64'(strobe5), 64'd0);
        strob5 = 1'b0;
        repeat (4) @(negedge clk);

        // Table-driven writes on the 4-register bank.
        for (int i = 0; i < 9; i++) apply(vecs[i]);

        // Reset without a clock edge clears the bank immediately.
        rst = 1'b1;
        #1;
        chk("async_rst_dirq", 64'(dir4), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset one cycle after the strobe rises aborts the write.
        a4 = 4'd0; d4 = 8'h99; ch4 = 1'b1; strob4 = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        strob4 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_dirq", 64'(dir4), 64'd0);

        // Strobe already high when reset falls: one fresh write 3 edges later.
        a4 = 4'd2; d4 = 8'h66; ch4 = 1'b1; strob4 = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        e.strobe = 4'b0100; e.ack = 1'b1; e.err = 1'b0; e.dirq = 32'h0066_0000; e.cyc = cyc + 3;
        sb.push_back(e);
        acc_pushed++;
        repeat (6) @(negedge clk);
        strob4 = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_release_dirq", 64'(dir4), 64'h0066_0000);

        chk("sb_drain", 64'(sb.size()), 64'd0);
        chk("ack_count", 64'(ack_cnt), 64'(acc_pushed));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dir_reg_bank.md
DIR_REG_BANK -- requirements
Module: dir_reg_bank

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  N_REGS, 4, number of direction registers, legal range 1..16
  DATA_W, 8, width of each direction register
  ADDR_W, 4, address width; SHALL satisfy 2**ADDR_W >= N_REGS
  RESET_VAL, 0, value loaded into every register on reset
REQ-002 Ports (name, direction, width, meaning), one per line, clock and reset first:
  clk  in  1  single system clock, rising edge active
  rst  in  1  reset, asynchronous, active-high
  A  in  ADDR_W  register address
  D  in  DATA_W  write data
  strob_in  in  1  bus write strobe, asynchronous to clk, active-high
  choose_dir_reg  in  1  bank select, active-high
  strob_out_to_reg  out  N_REGS  one-hot write strobe per register
  dir_q  out  N_REGS*DATA_W  register contents; register i occupies bits [i*DATA_W +: DATA_W]
  wr_ack  out  1  one-cycle pulse for an accepted write
  addr_err  out  1  one-cycle pulse for a selected write to an out-of-range address

Function
REQ-003 strob_in SHALL pass through a 2-flop synchronizer (s1, s2) followed by a history flop s3.
REQ-004 Rising edge rise = s2 & ~s3; exactly one rise per low-to-high strob_in transition held >= 2 clk periods.
REQ-005 On the clk edge where rise = 1, A, D and choose_dir_reg SHALL be sampled. The bus SHALL hold them stable from strob_in rise until strob_in fall.
REQ-006 Write accepted when rise & choose_dir_reg & (A < N_REGS).
REQ-007 On an accepted write:
  - register A loads D;
  - strob_out_to_reg[A] = 1 for exactly one cycle, all other bits 0;
  - wr_ack = 1 in that same cycle.
  All three SHALL be registered and become visible on the edge that samples rise.
REQ-008 Latency: strob_in rises before clk edge k; s1 = 1 after edge k, s2 after k+1, rise evaluated true at edge k+2. Strobe, ack and register update SHALL be visible after edge k+2, which is 3 edges inclusive.
REQ-009 If rise & choose_dir_reg & (A >= N_REGS):
  - no register changes;
  - strob_out_to_reg = 0;
  - wr_ack = 0;
  - addr_err = 1 for one cycle.
REQ-010 If rise & ~choose_dir_reg: no write, no strobe, no ack, no error.
REQ-011 strob_out_to_reg SHALL be one-hot or zero in every cycle; wr_ack and addr_err SHALL never be 1 in the same cycle.
REQ-012 strob_in held high for many cycles SHALL produce a single write. A new write requires strob_in low for >= 2 clk periods and then high again.
REQ-013 Back-to-back rises, separated by the minimum gap of REQ-012, SHALL each produce an independent write with no loss.
REQ-014 dir_q SHALL be driven directly from the register flops with no combinational path from inputs. Unused high bits, if any, do not exist: the width is exactly N_REGS*DATA_W.
REQ-015 A glitch on strob_in shorter than one clk period MAY be missed or produce one write. It SHALL never produce more than one write.

Reset
REQ-016 While rst = 1:
  - s1, s2, s3 = 0;
  - every register = RESET_VAL;
  - strob_out_to_reg = 0, wr_ack = 0, addr_err = 0.
  All SHALL take effect immediately, without waiting for clk.
REQ-017 rst asserted mid-write, between strob_in rise and the strobe pulse, SHALL abort the write with no register change.
REQ-018 After rst falls with strob_in already high, the synchronizer SHALL see a fresh rise, and one write SHALL occur 3 edges later.

Verification
REQ-019 Bench SHALL cover these directed scenarios (N_REGS=4, DATA_W=8 unless stated):
  - Reset check: after rst, dir_q = 32'h0000_0000, all outputs 0.
  - Basic write: A=2, D=8'hA5, choose=1, strob_in pulse 4 cycles -> after 3rd edge: strob_out_to_reg = 4'b0100 and wr_ack = 1 for 1 cycle; dir_q[23:16] = 8'hA5; other bytes unchanged.
  - Sequential writes: A=0..3 with D = 8'h11, 22, 33, 44 -> dir_q = 32'h4433_2211; exactly 4 wr_ack pulses.
  - Not selected: choose=0, A=1, D=8'hFF, strob pulse -> no strobe, no ack, dir_q unchanged.
  - Range error: N_REGS=5, ADDR_W=3, A=6 -> addr_err 1-cycle pulse, strob_out_to_reg = 0, dir_q unchanged. A=4 -> strob_out_to_reg = 5'b10000.
  - Long strobe and reset: strob_in held high 20 cycles -> exactly 1 write. rst pulsed 1 cycle after strob_in rise -> no write.
